// File: rtl/fxp_multiplier_seq.sv
// Iterative shift-add signed multiplier for the header-plus-mantissa fixed-point word.
// One operation in flight; valid/ready on both sides; overflow policy set by SATURATE.
module fxp_multiplier_seq #(
    parameter int WIDTH    = 16,
    parameter int FRAC_W   = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] first_operand,
    input  logic [WIDTH-1:0] second_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int M  = WIDTH - FRAC_W;
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [FRAC_W-1:0]   fo_q, fo_d;
    logic [FRAC_W-1:0]   sh_q, sh_d;
    logic                neg_q, neg_d;
    logic [2*M-1:0]      mcand_q, mcand_d;
    logic [M-1:0]        mplier_q, mplier_d;
    logic [2*M-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;

    logic [FRAC_W-1:0]   fa, fb;
    logic [M-1:0]        ma, mb, ma_mag, mb_mag;
    logic signed [2*M-1:0] prod_s, shf_s;
    logic [M:0]          hi_bits;
    logic                norm_ovf;
    logic [M-1:0]        norm_mo;

    assign fa = first_operand[WIDTH-1:M];
    assign fb = second_operand[WIDTH-1:M];
    assign ma = first_operand[M-1:0];
    assign mb = second_operand[M-1:0];
    // Magnitudes are unsigned M-bit, so the most negative mantissa maps to 2^(M-1) exactly.
    assign ma_mag = ma[M-1] ? (~ma + 1'b1) : ma;
    assign mb_mag = mb[M-1] ? (~mb + 1'b1) : mb;

    always_comb begin
        prod_s   = neg_q ? $signed(~acc_q + 1'b1) : $signed(acc_q);
        shf_s    = prod_s >>> sh_q;
        hi_bits  = shf_s[2*M-1:M-1];
        norm_ovf = !((&hi_bits) || (~|hi_bits));
        norm_mo  = shf_s[M-1:0];
        if (norm_ovf) begin
            if (SATURATE != 0) begin
                norm_mo = shf_s[2*M-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
            end else begin
                norm_mo = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fo_d        = fo_q;
        sh_d        = sh_q;
        neg_d       = neg_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fo_d     = (fa > fb) ? fa : fb;
                    sh_d     = (fa > fb) ? fb : fa;
                    neg_d    = ma[M-1] ^ mb[M-1];
                    mcand_d  = {{M{1'b0}}, ma_mag};
                    mplier_d = mb_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CW'(M - 1)) begin
                    cnt_d   = '0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NORM: begin
                out_d       = {fo_q, norm_mo};
                ovf_d       = norm_ovf;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fo_q        <= '0;
            sh_q        <= '0;
            neg_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fo_q        <= fo_d;
            sh_q        <= sh_d;
            neg_q       <= neg_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fxp_multiplier_seq.sv
// Directed bench for fxp_multiplier_seq (WIDTH=16, FRAC_W=3); wrap and saturate instances share stimulus.
module tb_fxp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] first_operand = '0;
    logic [15:0] second_operand = '0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [15:0] out0, out1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fxp_multiplier_seq #(.WIDTH(16), .FRAC_W(3), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .first_operand(first_operand), .second_operand(second_operand),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .overflow(ovf0)
    );

    fxp_multiplier_seq #(.WIDTH(16), .FRAC_W(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .first_operand(first_operand), .second_operand(second_operand),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .overflow(ovf1)
    );

    // Accept one pair, count edges until out_valid, then consume it.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                          output logic [15:0] r0, output logic [15:0] r1,
                          output logic v0, output logic v1);
        lat = -1;
        for (int i = 0; i < 40 && !in_ready0; i++) begin
            @(posedge clk); #1;
        end
        first_operand = a;
        second_operand = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        first_operand = 16'hFFFF;
        second_operand = 16'hFFFF;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                lat = e;
                break;
            end
        end
        r0 = out0;
        r1 = out1;
        v0 = ovf0;
        v1 = ovf1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (out0 !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", out0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    endtask

    task automatic test_basic();
        int lat;
        logic [15:0] r0, r1;
        logic v0, v1;
        run_op(16'h0002, 16'h0003, lat, r0, r1, v0, v1);
        total++; if (lat !== 14) begin bad++; $display("FAIL basic_latency: got %0d want 14", lat); end
        total++; if (r0 !== 16'h0006) begin bad++; $display("FAIL basic_out: got %h want 0006", r0); end
        total++; if (v0 !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", v0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after: got %b want 1", in_ready0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL basic_out_valid_after: got %b want 0", out_valid0); end
    endtask

    task automatic test_fraction();
        // {a, b, expected out}
        logic [15:0] vec [4][3];
        int lat;
        logic [15:0] r0, r1;
        logic v0, v1;
        vec[0] = '{16'h2007, 16'h8054, 16'h8126};  // 3.5 * 5.25 = 18.375
        vec[1] = '{16'h3FF3, 16'h0004, 16'h3FCC};  // -6.5 * 4 = -26
        vec[2] = '{16'hA0A3, 16'hA0B1, 16'hA385};  // 28851 >> 5 = 901
        vec[3] = '{16'h3FFD, 16'h2001, 16'h3FFE};  // -3 >>> 1 = -2 (toward -inf)
        for (int i = 0; i < 4; i++) begin
            run_op(vec[i][0], vec[i][1], lat, r0, r1, v0, v1);
            total++; if (r0 !== vec[i][2]) begin bad++; $display("FAIL frac_out[%0d]: got %h want %h", i, r0, vec[i][2]); end
            total++; if (r1 !== vec[i][2]) begin bad++; $display("FAIL frac_out_sat[%0d]: got %h want %h", i, r1, vec[i][2]); end
            total++; if (v0 !== 1'b0 || v1 !== 1'b0) begin bad++; $display("FAIL frac_ovf[%0d]: got %b%b want 00", i, v0, v1); end
            total++; if (lat !== 14) begin bad++; $display("FAIL frac_latency[%0d]: got %0d want 14", i, lat); end
        end
    endtask

    task automatic test_overflow();
        // {a, b, expected wrap out, expected saturate out}
        logic [15:0] vec [3][4];
        int lat;
        logic [15:0] r0, r1;
        logic v0, v1;
        vec[0] = '{16'hE800, 16'hE200, 16'hE000, 16'hEFFF};  // 16 * 4
        vec[1] = '{16'h1000, 16'h1FFF, 16'h0000, 16'h0FFF};  // -4096 * -1 = 4096
        vec[2] = '{16'h1000, 16'h0002, 16'h0000, 16'h1000};  // -4096 * 2 = -8192
        for (int i = 0; i < 3; i++) begin
            run_op(vec[i][0], vec[i][1], lat, r0, r1, v0, v1);
            total++; if (r0 !== vec[i][2]) begin bad++; $display("FAIL ovf_wrap_out[%0d]: got %h want %h", i, r0, vec[i][2]); end
            total++; if (r1 !== vec[i][3]) begin bad++; $display("FAIL ovf_sat_out[%0d]: got %h want %h", i, r1, vec[i][3]); end
            total++; if (v0 !== 1'b1 || v1 !== 1'b1) begin bad++; $display("FAIL ovf_flag[%0d]: got %b%b want 11", i, v0, v1); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        logic stable_ok, ready_low_ok, valid_ok, seen;
        int lat;
        logic [15:0] r0, r1;
        logic v0, v1;
        first_operand = 16'h2007;
        second_operand = 16'h8054;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_out_valid_timeout: got %b want 1", seen); end
        held = out0;
        total++; if (held !== 16'h8126) begin bad++; $display("FAIL bp_out: got %h want 8126", held); end
        stable_ok = 1'b1;
        ready_low_ok = 1'b1;
        valid_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            first_operand = 16'h0002;
            second_operand = 16'h0003;
            @(posedge clk); #1;
            if (out0 !== held || ovf0 !== 1'b0) stable_ok = 1'b0;
            if (in_ready0 !== 1'b0) ready_low_ok = 1'b0;
            if (out_valid0 !== 1'b1) valid_ok = 1'b0;
        end
        in_valid = 1'b0;
        total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", stable_ok); end
        total++; if (ready_low_ok !== 1'b1) begin bad++; $display("FAIL bp_in_ready_low: got %b want 1", ready_low_ok); end
        total++; if (valid_ok !== 1'b1) begin bad++; $display("FAIL bp_out_valid_held: got %b want 1", valid_ok); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid0); end
        run_op(16'h3FF3, 16'h0004, lat, r0, r1, v0, v1);
        total++; if (r0 !== 16'h3FCC) begin bad++; $display("FAIL bp_next_out: got %h want 3FCC", r0); end
        total++; if (lat !== 14) begin bad++; $display("FAIL bp_next_latency: got %0d want 14", lat); end
    endtask

    task automatic test_out_ready_early();
        int lat = -1;
        first_operand = 16'h0002;
        second_operand = 16'h0003;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                lat = e;
                break;
            end
        end
        total++; if (lat !== 14) begin bad++; $display("FAIL early_latency: got %0d want 14", lat); end
        total++; if (out0 !== 16'h0006) begin bad++; $display("FAIL early_out: got %h want 0006", out0); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL early_consumed: got %b want 0", out_valid0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL early_in_ready: got %b want 1", in_ready0); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int lat;
        logic [15:0] r0, r1;
        logic v0, v1;
        first_operand = 16'h2007;
        second_operand = 16'h8054;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out0 !== 16'h0000) begin bad++; $display("FAIL midrst_out: got %h want 0000", out0); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready0); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid0 || out_valid1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_out_valid: got %b want 0", seen); end
        run_op(16'h0002, 16'h0003, lat, r0, r1, v0, v1);
        total++; if (r0 !== 16'h0006) begin bad++; $display("FAIL midrst_fresh_out: got %h want 0006", r0); end
        total++; if (lat !== 14) begin bad++; $display("FAIL midrst_fresh_latency: got %0d want 14", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_overflow();
        test_backpressure();
        test_out_ready_early();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fxp_multiplier_seq.md
# fxp_multiplier_seq

Parametrised, iterative (shift-add) signed multiplier for the team's self-describing fixed-point word: a FRAC_W-bit fraction-count header followed by a signed mantissa. It supersedes the combinational 16-bit multiplier in the ODE datapath. It adds width/format generics, a valid/ready handshake on both sides, a multi-cycle area-lean datapath, and a selectable overflow policy (wrap-to-zero or saturate). One multiply is in flight at a time.

## Interface
- WIDTH, 16, total word width.
- FRAC_W, 3, header width. The header holds the fraction-bit count f. The mantissa width is M = WIDTH-FRAC_W. Legal only if FRAC_W ≥ 1 and 2^FRAC_W-1 < M.
- SATURATE, 0, overflow policy. 0 = output mantissa forced to 0. 1 = output mantissa clamped to the most positive or most negative M-bit value.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- first_operand  in  WIDTH  {fa, ma}. Value = signed(ma)/2^fa.
- second_operand  in  WIDTH  {fb, mb}.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  {fo, mo} result word.
- overflow  out  1  result did not fit in M signed bits; qualified by out_valid.

## Operation
- Result format: fo = max(fa, fb). The full product is P = ma·mb (2M bits, signed), carrying fa+fb fraction bits. Then S = P >>> min(fa, fb): arithmetic shift, i.e. truncation toward −∞.
- Overflow: asserted when S > 2^(M-1)-1 or S < −2^(M-1).
  - SATURATE=0: mo = 0, header fo kept.
  - SATURATE=1: mo = 2^(M-1)-1 if S > 0, otherwise −2^(M-1).
- No overflow: mo = S[M-1:0] and overflow = 0.
- Datapath uses sign-magnitude:
  - |ma| and |mb| are taken as M-bit unsigned values, so −2^(M-1) is representable.
  - One multiplier bit is processed per MUL cycle, shift-add into a 2M-bit accumulator.
  - In NORM, the accumulator is negated if sign(ma) ≠ sign(mb), then shifted, range-checked and registered.
- FSM states:
  - IDLE: in_ready=1. On in_valid, the operands are captured → MUL.
  - MUL: M cycles, counter from 0 to M-1 → NORM.
  - NORM: 1 cycle; out, overflow and out_valid are registered → DONE.
  - DONE: out_valid=1. On out_ready → IDLE.
- in_ready = (state == IDLE). It is combinational from state only and never depends on in_valid.
- Operands are sampled only on the accepting edge. Input changes afterwards are ignored.
- out and overflow hold stable throughout DONE while out_ready=0 (backpressure).
- Zero operand: the normal path applies, no early exit. Latency is data-independent.

## Timing
- Reset values, on any edge with rst=1 (overrides everything, including mid-MUL and DONE):
  - state = IDLE, out = 0, overflow = 0, out_valid = 0, counter = 0.
  - in_ready reads 1 from the first cycle after rst falls.
- Latency: call the accepting edge (in_valid & in_ready) edge 0. out_valid rises at edge M+1. With WIDTH=16 and FRAC_W=3, that is edge 14.
- The result is consumed on an edge with out_valid & out_ready. out_valid falls at that edge and in_ready = 1 in the following cycle.
- Minimum initiation interval is M+3 cycles, which includes the IDLE cycle. Back-to-back acceptance in DONE is not allowed.
- out_ready held high in advance: the handshake completes on the first DONE edge.
- in_valid asserted outside IDLE is ignored with no side effects. The source must hold in_valid until in_ready.
- Reset asserted during MUL or DONE discards the operation. No out_valid is produced for it.

## Test plan
All values use WIDTH=16, FRAC_W=3.
- 0x0002 × 0x0003 (2 × 3, f=0) → out 0x0006, overflow 0, out_valid at edge 14 after accept.
- {1, 7} × {4, 84} (3.5 × 5.25) → out {4, 294} (18.375), overflow 0. Then {1, −13} × {0, 4} (−6.5 × 4) → out {1, −52} (−26), overflow 0.
- {5, 163} × {5, 177} → out {5, 901} (28.15625, truncated), overflow 0.
- {7, 2048} × {7, 512} (16 × 4), SATURATE=0 → out {7, 0}, overflow 1. Same stimulus with SATURATE=1 → out {7, 4095}, overflow 1. Also {0, −4096} × {0, −1} → overflow 1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: out stable, in_ready=0, in_valid pulses ignored. Release out_ready → in_ready=1 on the next cycle. The next operand pair is then accepted and computed correctly.
- Pulse rst at MUL cycle 6. Required: out_valid never rises for that operation, out = 0 and in_ready = 1 after reset. A fresh 2 × 3 then completes with latency 14.
